// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, the next-PC select encoding and the word-alignment helper
// used by the pipeline control blocks.
package pipe_ctrl_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;
   localparam logic [31:0] PC_STEP            = 32'd4;
   localparam int          MULT_CYCLES_DEFAULT = 5;
   localparam int          DIV_CYCLES_DEFAULT  = 10;

   typedef enum logic [1:0] {
      SEL_SEQ,
      SEL_BR,
      SEL_PEND,
      SEL_EXC
   } pcSel_t;

   function automatic logic [31:0] alignWord(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy counter: loads the unit latency on an accepted issue,
// counts down to zero and flags busy and a single completion pulse.
module md_busy_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic md_start,
   input  logic md_is_div,
   output logic md_busy,
   output logic md_done
);

   localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);

   logic [CW-1:0] mdCnt;
   logic [CW-1:0] mdCntNext;

   // An issue while the unit is still counting is dropped; ID holds the
   // dependent instruction through md_use instead.
   always_comb begin
      mdCntNext = mdCnt;
      if (md_start && (mdCnt == '0)) begin
         mdCntNext = md_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (mdCnt != '0) begin
         mdCntNext = mdCnt - CW'(1);
      end
   end

   // Busy tracks the count that will be held after the edge, so it drops in
   // the same cycle that the done pulse rises.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mdCnt   <= '0;
         md_busy <= 1'b0;
         md_done <= 1'b0;
      end else begin
         mdCnt   <= mdCntNext;
         md_busy <= (mdCntNext != '0);
         md_done <= (mdCnt == CW'(1));
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks the fetch address, gates the PC load, kills the
// wrong-path fetch and holds redirects that arrive while the front end is stalled.
module pc_sequencer
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
   parameter int          MULT_CYCLES = MULT_CYCLES_DEFAULT,
   parameter int          DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc_current,
   input  logic        load_use_stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump_valid,
   input  logic [31:0] jump_target,
   input  logic        exc_req,
   input  logic        md_start,
   input  logic        md_is_div,
   input  logic        md_use,
   output logic [31:0] next_pc,
   output logic        pc_enable,
   output logic        stall_if_id,
   output logic        flush_if,
   output logic        md_busy,
   output logic        md_done
);

   logic        stall;
   logic        redirect;
   logic [31:0] target;
   logic        pcEnable;
   pcSel_t      pcSel;
   logic [31:0] selPc;
   logic        pendValid;
   logic [31:0] pendTarget;

   md_busy_counter #(
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_mdBusyCounter (
      .clock    (clock),
      .reset    (reset),
      .md_start (md_start),
      .md_is_div(md_is_div),
      .md_busy  (md_busy),
      .md_done  (md_done)
   );

   // Jumps outrank branches when both resolve in the same ID cycle.
   always_comb begin
      stall    = load_use_stall | (md_busy & md_use);
      redirect = jump_valid | branch_taken;
      target   = jump_valid ? jump_target : branch_target;
      pcEnable = exc_req | ~stall;
   end

   always_comb begin
      pcSel = SEL_SEQ;
      if (exc_req) begin
         pcSel = SEL_EXC;
      end else if (pendValid) begin
         pcSel = SEL_PEND;
      end else if (redirect) begin
         pcSel = SEL_BR;
      end
   end

   always_comb begin
      selPc = pc_current + PC_STEP;
      case (pcSel)
         SEL_EXC:  selPc = EXC_VECTOR;
         SEL_PEND: selPc = pendTarget;
         SEL_BR:   selPc = target;
         default:  selPc = pc_current + PC_STEP;
      endcase
   end

   // While reset is held the PC register keeps loading RESET_PC, so the first
   // fetch after release comes from RESET_PC.
   always_comb begin
      if (reset) begin
         next_pc     = RESET_PC;
         pc_enable   = 1'b1;
         stall_if_id = 1'b0;
         flush_if    = 1'b1;
      end else begin
         next_pc     = alignWord(selPc);
         pc_enable   = pcEnable;
         stall_if_id = stall & ~exc_req;
         flush_if    = pcEnable & (exc_req | pendValid | redirect);
      end
   end

   // Any PC load consumes the held redirect (an exception simply discards it);
   // a redirect seen while stalled is parked, the newest one winning.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pendValid  <= 1'b0;
         pendTarget <= '0;
      end else if (pcEnable) begin
         pendValid <= 1'b0;
      end else if (redirect) begin
         pendValid  <= 1'b1;
         pendTarget <= target;
      end
   end

endmodule
